// File: rtl/mdu_divider.sv
// ============================================================================
// Module      : mdu_divider
// Description : Iterative restoring radix-2 divide/remainder unit for RV64M
//               (DIV/DIVU/REM/REMU and W forms), request/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0]   C_N_FULL = CW'(XLEN);
    localparam logic [CW-1:0]   C_N_WORD = CW'(32);
    localparam logic [XLEN-1:0] C_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [1:0]      r_op;
    logic            r_word;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_sign_q;
    logic            r_sign_r;
    logic [XLEN-1:0] r_res;

    // Operand preparation (consumed in PREP)
    logic            w_signed;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec;
    logic [XLEN-1:0] w_spec_out;

    assign w_signed = ~r_op[0];
    assign w_a_ext  = r_word ? (w_signed ? sext32(r_a[31:0]) : {{(XLEN-32){1'b0}}, r_a[31:0]}) : r_a;
    assign w_b_ext  = r_word ? (w_signed ? sext32(r_b[31:0]) : {{(XLEN-32){1'b0}}, r_b[31:0]}) : r_b;
    assign w_sa     = w_signed & w_a_ext[XLEN-1];
    assign w_sb     = w_signed & w_b_ext[XLEN-1];
    assign w_mag_a  = w_sa ? -w_a_ext : w_a_ext;
    assign w_mag_b  = w_sb ? -w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == '0);
    assign w_ovf    = w_signed & (r_word ? ((r_a[31:0] == 32'h8000_0000) && (r_b[31:0] == 32'hFFFF_FFFF))
                                         : ((r_a == C_MIN) && (r_b == '1)));

    // Divide-by-zero and signed overflow short-circuit straight to DONE
    assign w_spec     = r_op[1] ? (w_b_zero ? w_a_ext : '0) : (w_b_zero ? '1 : w_a_ext);
    assign w_spec_out = r_word ? sext32(w_spec[31:0]) : w_spec;

    // One restoring step
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[XLEN-1:0] - r_div;

    // Sign fix-up and result selection
    logic [XLEN-1:0] w_quo_f;
    logic [XLEN-1:0] w_rem_f;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_out;

    assign w_quo_f = r_sign_q ? -r_quo : r_quo;
    assign w_rem_f = r_sign_r ? -r_rem : r_rem;
    assign w_sel   = r_op[1] ? w_rem_f : w_quo_f;
    assign w_out   = r_word ? sext32(w_sel[31:0]) : w_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_state_nxt = S_PREP;
            S_PREP: w_state_nxt = (w_b_zero || w_ovf) ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op     <= '0;
            r_word   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_res    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        r_op   <= op;
                        r_word <= word;
                        r_a    <= a;
                        r_b    <= b;
                    end
                end
                S_PREP: begin
                    r_sign_q <= w_sa ^ w_sb;
                    r_sign_r <= w_sa;
                    r_rem    <= '0;
                    // W dividends sit in the top half so 32 shifts bring every bit through
                    r_quo    <= r_word ? (w_mag_a << (XLEN - 32)) : w_mag_a;
                    r_div    <= w_mag_b;
                    r_cnt    <= r_word ? C_N_WORD : C_N_FULL;
                    if (w_b_zero || w_ovf) r_res <= w_spec_out;
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_res <= w_out;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign res        = r_res;

endmodule

`default_nettype wire
